// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator with a one-stage registered pixel pipeline.
// x/y address the next pixel; rgb_out/hsync/vsync/de/strobes lag them by one ce edge.
module vga_timing_gen #(
  parameter int       H_ACTIVE = 360,
  parameter int       H_FRONT  = 6,
  parameter int       H_SYNC   = 32,
  parameter int       H_BACK   = 57,
  parameter int       V_ACTIVE = 600,
  parameter int       V_FRONT  = 1,
  parameter int       V_SYNC   = 2,
  parameter int       V_BACK   = 23,
  parameter logic     H_POL    = 1'b0,
  parameter logic     V_POL    = 1'b0,
  parameter int       CW       = 12
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          ce,
  input  logic          blank,
  input  logic [2:0]    rgb_in,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          req,
  output logic [2:0]    rgb_out,
  output logic          hsync,
  output logic          vsync,
  output logic          de,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_ACTIVE + V_FRONT + V_SYNC + V_BACK;

  localparam logic [CW-1:0] H_LAST    = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST    = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT     = CW'(H_ACTIVE);
  localparam logic [CW-1:0] V_ACT     = CW'(V_ACTIVE);
  // Inclusive bounds avoid overflow when the sync pulse ends on the last count.
  localparam logic [CW-1:0] HS_FIRST  = CW'(H_ACTIVE + H_FRONT);
  localparam logic [CW-1:0] HS_LAST   = CW'(H_ACTIVE + H_FRONT + H_SYNC - 1);
  localparam logic [CW-1:0] VS_FIRST  = CW'(V_ACTIVE + V_FRONT);
  localparam logic [CW-1:0] VS_LAST   = CW'(V_ACTIVE + V_FRONT + V_SYNC - 1);

  logic [CW-1:0] x_q, x_d;
  logic [CW-1:0] y_q, y_d;
  logic [2:0]    rgb_q, rgb_d;
  logic          hsync_q, hsync_d;
  logic          vsync_q, vsync_d;
  logic          de_q, de_d;
  logic          line_start_q, line_start_d;
  logic          frame_start_q, frame_start_d;

  assign req = (x_q < H_ACT) && (y_q < V_ACT);

  always_comb begin
    // NOTE: every signal gets a hold/default value first, so no path leaves one unassigned and no latch is inferred.
    x_d           = x_q;
    y_d           = y_q;
    rgb_d         = rgb_q;
    hsync_d       = hsync_q;
    vsync_d       = vsync_q;
    de_d          = de_q;
    line_start_d  = 1'b0;
    frame_start_d = 1'b0;

    if (ce) begin
      if (x_q == H_LAST) begin
        x_d = '0;
        y_d = (y_q == V_LAST) ? '0 : y_q + CW'(1);
      end else begin
        x_d = x_q + CW'(1);
      end

      // Output stage samples the pre-increment coordinate.
      de_d          = req;
      rgb_d         = (req && !blank) ? rgb_in : 3'b000;
      hsync_d       = (x_q >= HS_FIRST && x_q <= HS_LAST) ? H_POL : ~H_POL;
      vsync_d       = (y_q >= VS_FIRST && y_q <= VS_LAST) ? V_POL : ~V_POL;
      line_start_d  = (x_q == '0);
      frame_start_d = (x_q == '0) && (y_q == '0);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      x_q           <= '0;
      y_q           <= '0;
      rgb_q         <= 3'b000;
      hsync_q       <= ~H_POL;
      vsync_q       <= ~V_POL;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      rgb_q         <= rgb_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign x           = x_q;
  assign y           = y_q;
  assign rgb_out     = rgb_q;
  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign de          = de_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default geometry (dut_a) and a tiny inverted-polarity geometry (dut_b),
// checked against a pixel-index reference model plus directed vectors and period measurements.
module tb_vga_timing_gen;

  typedef struct {
    int ha, hf, hs, hb, va, vf, vs, vb;
    bit hp, vp;
  } geom_t;

  typedef struct {
    int         p;
    logic [2:0] rgb;
    logic       hs, vs, de, ls, fs;
  } model_t;

  typedef struct {
    logic       ce, blank;
    logic [2:0] rgb;
    int         ex, ey;
    logic       ede;
    logic [2:0] ergb;
    logic       ehs, evs, els, efs;
  } vec_t;

  logic CLK = 1'b0;
  logic RST = 1'b0;
  always #5 CLK = ~CLK;

  logic        ce_a, blank_a, ce_b, blank_b;
  logic [2:0]  rgb_in_a, rgb_in_b;
  logic [11:0] x_a, y_a;
  logic [3:0]  x_b, y_b;
  logic        req_a, req_b, hs_a, hs_b, vs_a, vs_b, de_a, de_b, ls_a, ls_b, fs_a, fs_b;
  logic [2:0]  rgb_a, rgb_b;

  vga_timing_gen dut_a (
    .CLK(CLK), .RST(RST), .ce(ce_a), .blank(blank_a), .rgb_in(rgb_in_a),
    .x(x_a), .y(y_a), .req(req_a), .rgb_out(rgb_a), .hsync(hs_a), .vsync(vs_a),
    .de(de_a), .line_start(ls_a), .frame_start(fs_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(4), .H_FRONT(1), .H_SYNC(2), .H_BACK(1),
    .V_ACTIVE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .H_POL(1'b1), .V_POL(1'b1), .CW(4)
  ) dut_b (
    .CLK(CLK), .RST(RST), .ce(ce_b), .blank(blank_b), .rgb_in(rgb_in_b),
    .x(x_b), .y(y_b), .req(req_b), .rgb_out(rgb_b), .hsync(hs_b), .vsync(vs_b),
    .de(de_b), .line_start(ls_b), .frame_start(fs_b)
  );

  geom_t ga = '{360, 6, 32, 57, 600, 1, 2, 23, 1'b0, 1'b0};
  geom_t gb = '{4, 1, 2, 1, 3, 1, 1, 1, 1'b1, 1'b1};

  int n_cmp  = 0;
  int n_fail = 0;
  bit mon_en = 1'b0;
  model_t ma, mb;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int htot(geom_t g);
    return g.ha + g.hf + g.hs + g.hb;
  endfunction

  function automatic int vtot(geom_t g);
    return g.va + g.vf + g.vs + g.vb;
  endfunction

  function automatic model_t m_reset(geom_t g);
    model_t m;
    m.p = 0; m.rgb = 3'b000; m.hs = !g.hp; m.vs = !g.vp;
    m.de = 1'b0; m.ls = 1'b0; m.fs = 1'b0;
    return m;
  endfunction

  // Pixel index p walks 0..H_TOTAL*V_TOTAL-1; x and y are its remainder and quotient.
  function automatic model_t m_step(model_t m, geom_t g, logic ce, logic blank, logic [2:0] rgb);
    model_t n = m;
    int px = m.p % htot(g);
    int py = m.p / htot(g);
    bit act = (px < g.ha) && (py < g.va);
    n.ls = 1'b0;
    n.fs = 1'b0;
    if (ce) begin
      n.de  = act;
      n.rgb = (act && !blank) ? rgb : 3'b000;
      n.hs  = (px >= g.ha + g.hf && px < g.ha + g.hf + g.hs) ? g.hp : !g.hp;
      n.vs  = (py >= g.va + g.vf && py < g.va + g.vf + g.vs) ? g.vp : !g.vp;
      n.ls  = (px == 0);
      n.fs  = (m.p == 0);
      n.p   = (m.p + 1) % (htot(g) * vtot(g));
    end
    return n;
  endfunction

  function automatic logic [63:0] exp_vec(model_t m, geom_t g);
    int px = m.p % htot(g);
    int py = m.p / htot(g);
    logic r = (px < g.ha) && (py < g.va);
    return {23'b0, 16'(px), 16'(py), r, m.rgb, m.hs, m.vs, m.de, m.ls, m.fs};
  endfunction

  always @(posedge CLK or posedge RST) begin
    if (RST) begin
      ma = m_reset(ga);
      mb = m_reset(gb);
    end else begin
      ma = m_step(ma, ga, ce_a, blank_a, rgb_in_a);
      mb = m_step(mb, gb, ce_b, blank_b, rgb_in_b);
    end
  end

  always @(negedge CLK) begin
    if (mon_en) begin
      check("model_a", {23'b0, 16'(x_a), 16'(y_a), req_a, rgb_a, hs_a, vs_a, de_a, ls_a, fs_a},
            exp_vec(ma, ga));
      check("model_b", {23'b0, 16'(x_b), 16'(y_b), req_b, rgb_b, hs_b, vs_b, de_b, ls_b, fs_b},
            exp_vec(mb, gb));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    ce_a = 1'b0; ce_b = 1'b0; blank_a = 1'b0; blank_b = 1'b0;
    RST = 1'b1;
    step();
    step();
    RST = 1'b0;
  endtask

  // Runs dut_a with ce high one cycle in div and measures the first full line.
  task automatic measure_line(input int div, input int n, output int period, output int hs_first,
                              output int hs_low, output int de_hi, output int ls_hi);
    int ls_t[$];
    int t0;
    hs_first = -1; hs_low = 0; de_hi = 0; ls_hi = 0; t0 = -1;
    for (int t = 0; t < n; t++) begin
      ce_a = (t % div == 0);
      step();
      if (ls_a) ls_t.push_back(t);
      if (ls_t.size() > 0 && t0 < 0) t0 = ls_t[0];
      if (t0 >= 0 && t < t0 + 455 * div) begin
        if (!hs_a && hs_first < 0) hs_first = t - t0;
        if (!hs_a) hs_low++;
        if (de_a) de_hi++;
        if (ls_a) ls_hi++;
      end
    end
    period = (ls_t.size() >= 2) ? ls_t[1] - ls_t[0] : -1;
    ce_a = 1'b0;
  endtask

  vec_t vecs[10];

  initial begin
    int period, hs_first, hs_low, de_hi, ls_hi, bad_rgb, bad_de, fs_cnt, vs_cnt;
    bit found;

    vecs[0] = '{1'b1, 1'b0, 3'd5, 1, 0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[1] = '{1'b0, 1'b0, 3'd7, 1, 0, 1'b1, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 3'd7, 2, 0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 3'd3, 3, 0, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[4] = '{1'b1, 1'b0, 3'd6, 4, 0, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 3'd7, 5, 0, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 3'd7, 6, 0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7] = '{1'b1, 1'b0, 3'd7, 7, 0, 1'b0, 3'd0, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[8] = '{1'b1, 1'b0, 3'd2, 0, 1, 1'b0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9] = '{1'b1, 1'b0, 3'd2, 1, 1, 1'b1, 3'd2, 1'b0, 1'b0, 1'b1, 1'b0};

    ce_a = 1'b0; ce_b = 1'b0; blank_a = 1'b0; blank_b = 1'b0;
    rgb_in_a = 3'd0; rgb_in_b = 3'd0;
    #1 RST = 1'b1;
    mon_en = 1'b1;
    step();
    step();

    // Reset values and idle sync levels of both polarities.
    check("rst_xy_a", {x_a, y_a}, 24'd0);
    check("rst_req_a", req_a, 1'b1);
    check("rst_outs_a", {rgb_a, de_a, ls_a, fs_a}, 6'd0);
    check("rst_sync_a", {hs_a, vs_a}, 2'b11);
    check("rst_sync_b", {hs_b, vs_b}, 2'b00);
    RST = 1'b0;
    step();
    check("post_rst_sync_b", {hs_b, vs_b}, 2'b00);

    // Directed vectors on the small geometry.
    for (int i = 0; i < 10; i++) begin
      ce_b = vecs[i].ce; blank_b = vecs[i].blank; rgb_in_b = vecs[i].rgb;
      step();
      check($sformatf("vec%0d_xy", i), {x_b, y_b}, {4'(vecs[i].ex), 4'(vecs[i].ey)});
      check($sformatf("vec%0d_out", i), {de_b, rgb_b, hs_b, vs_b, ls_b, fs_b},
            {vecs[i].ede, vecs[i].ergb, vecs[i].ehs, vecs[i].evs, vecs[i].els, vecs[i].efs});
    end

    // Exact raster walk and frame wrap on the small geometry.
    do_reset();
    ce_b = 1'b1; blank_b = 1'b0;
    for (int k = 0; k < 47; k++) begin
      step();
      if (x_b != 4'((k + 1) % 8) || y_b != 4'(((k + 1) / 8) % 6))
        check($sformatf("walk%0d", k), {x_b, y_b}, {4'((k + 1) % 8), 4'(((k + 1) / 8) % 6)});
    end
    check("walk_last", {x_b, y_b}, {4'd7, 4'd5});
    step();
    check("wrap_xy", {x_b, y_b}, 8'd0);
    check("wrap_fs_not_yet", fs_b, 1'b0);
    step();
    check("wrap_fs", {fs_b, ls_b}, 2'b11);
    fs_cnt = 0; vs_cnt = 0;
    for (int t = 0; t < 96; t++) begin
      step();
      if (fs_b) fs_cnt++;
      if (vs_b) vs_cnt++;
    end
    check("frame_fs_count", fs_cnt, 2);
    check("frame_vs_high", vs_cnt, 16);
    ce_b = 1'b0;

    // Default geometry, ce tied high.
    do_reset();
    measure_line(1, 1000, period, hs_first, hs_low, de_hi, ls_hi);
    check("line_period", period, 455);
    check("hsync_offset", hs_first, 366);
    check("hsync_width", hs_low, 32);
    check("de_per_line", de_hi, 360);
    check("ls_width", ls_hi, 1);

    // Default geometry, ce one cycle in three.
    do_reset();
    measure_line(3, 3000, period, hs_first, hs_low, de_hi, ls_hi);
    check("line_period_div3", period, 1365);
    check("hsync_offset_div3", hs_first, 1098);
    check("hsync_width_div3", hs_low, 96);
    check("de_per_line_div3", de_hi, 1080);
    check("ls_width_div3", ls_hi, 1);

    // Constant colour with a single blanked pixel at x=10.
    do_reset();
    ce_a = 1'b1; rgb_in_a = 3'b101;
    bad_rgb = 0; bad_de = 0;
    for (int t = 0; t < 455; t++) begin
      blank_a = (x_a == 12'd10);
      step();
      if (rgb_a != ((t < 360 && t != 10) ? 3'b101 : 3'b000)) bad_rgb++;
      if (de_a != (t < 360)) bad_de++;
      if (t == 10) check("blank_px10", {de_a, rgb_a}, {1'b1, 3'b000});
    end
    check("blank_rgb_line", bad_rgb, 0);
    check("blank_de_line", bad_de, 0);
    ce_a = 1'b0; blank_a = 1'b0;

    // Asynchronous reset in mid-frame.
    do_reset();
    ce_b = 1'b1;
    found = 1'b0;
    for (int t = 0; t < 100 && !found; t++) begin
      step();
      if (x_b == 4'd2 && y_b == 4'd1) found = 1'b1;
    end
    check("midrst_reached", found, 1'b1);
    #2 RST = 1'b1;
    #1;
    check("midrst_immediate",
          {x_b, y_b, req_b, rgb_b, de_b, hs_b, vs_b, ls_b, fs_b},
          {4'd0, 4'd0, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0});
    repeat (3) @(posedge CLK);
    #1;
    check("midrst_hold", {x_b, y_b, de_b, hs_b, vs_b}, 11'd0);
    RST = 1'b0;
    step();
    check("midrst_first_edge", {fs_b, ls_b, de_b, x_b}, {1'b1, 1'b1, 1'b1, 4'd1});

    // Randomised stimulus, checked by the reference model every cycle.
    for (int t = 0; t < 4000; t++) begin
      ce_a = ($urandom_range(0, 3) != 0);
      ce_b = ($urandom_range(0, 3) != 0);
      blank_a = ($urandom_range(0, 3) == 0);
      blank_b = ($urandom_range(0, 3) == 0);
      rgb_in_a = 3'($urandom);
      rgb_in_b = 3'($urandom);
      step();
    end

    @(negedge CLK);
    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
